dest_addr_sel_pipe: RTL and testbench

Parametrised, pipelined successor of the 2:1 5-bit register-address selector in the register-file write path. Selects one of NUM_IN destination-register addresses (rt, rd, $ra, …) per transaction and carries it through STAGES registered stages with valid/ready backpressure, flush and zero-register write suppression. Sits between decode and the register-file write port of the pipelined core.

---
 rtl/dest_addr_sel_pipe_pkg.sv | 17 +
 rtl/dest_addr_sel_pipe_if.sv | 29 ++
 rtl/dest_addr_sel_pipe_stage.sv | 38 +++
 rtl/dest_addr_sel_pipe.sv | 96 +++++++++
 tb/tb_dest_addr_sel_pipe.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dest_addr_sel_pipe_pkg.sv
// Shared constants and helpers for the destination-register address select pipeline.
package dest_sel_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;
    localparam int MAX_NUM_IN = 16;
    localparam int MAX_STAGES = 4;

    // Select width for n candidates, never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dest_addr_sel_pipe_if.sv
// Candidate-address input and selected-address output handshakes of the select pipeline.
interface dest_addr_sel_pipe_if
    import dest_sel_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = clog2(NUM_IN);

    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_W-1:0]         in_sel;
    logic [NUM_IN*ADDR_W-1:0] in_addr;
    logic                     out_valid;
    logic                     out_ready;
    logic [ADDR_W-1:0]        out_addr;
    logic                     out_wr_en;

    modport master (
        output in_valid, in_sel, in_addr, out_ready,
        input  in_ready, out_valid, out_addr, out_wr_en
    );

    modport slave (
        input  in_valid, in_sel, in_addr, out_ready,
        output in_ready, out_valid, out_addr, out_wr_en
    );

endinterface

// File: rtl/dest_addr_sel_pipe_stage.sv
// One valid/address/write-enable register stage; loads from upstream when advance is high.
// Holds its contents while stalled; flush and reset empty it.
module dest_sel_stage
    import dest_sel_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              advance,
    input  logic              prev_valid,
    input  logic [ADDR_W-1:0] prev_addr,
    input  logic              prev_wr_en,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            addr  <= '0;
            wr_en <= 1'b0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (advance) begin
                valid <= prev_valid;
            end
            if (advance) begin
                addr  <= prev_addr;
                wr_en <= prev_wr_en;
            end
        end
    end

endmodule

// File: rtl/dest_addr_sel_pipe.sv
// Selects one of NUM_IN register addresses and carries it through STAGES elastic stages.
// Latency STAGES cycles; ready ripples back from out_ready, capacity is exactly STAGES entries.
module dest_addr_sel_pipe
    import dest_sel_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_IN = 4,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    dest_addr_sel_pipe_if.slave  bus,
    output logic                 sel_err
);

    localparam int SEL_W = clog2(NUM_IN);

    logic              in_range;
    logic              in_fire;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_wr_en;
    logic [STAGES:0]   adv;
    logic [STAGES-1:0] st_valid;
    logic [STAGES-1:0] st_wr_en;
    logic [ADDR_W-1:0] st_addr [STAGES];

    // An out-of-range select matches no candidate and leaves the address at zero.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (bus.in_sel == SEL_W'(i)) begin
                sel_addr = bus.in_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign in_range  = 32'(bus.in_sel) < 32'(NUM_IN);
    assign sel_wr_en = in_range && (sel_addr != ADDR_W'(REG_ZERO));

    // A stage may load if it is empty or its contents move on this cycle.
    always_comb begin
        adv         = '0;
        adv[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !st_valid[k] || adv[k+1];
        end
    end

    assign bus.in_ready = adv[0] && !flush && !reset;
    assign in_fire      = bus.in_valid && bus.in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic              prev_valid;
        logic [ADDR_W-1:0] prev_addr;
        logic              prev_wr_en;

        if (k == 0) begin : g_head
            assign prev_valid = in_fire;
            assign prev_addr  = sel_addr;
            assign prev_wr_en = sel_wr_en;
        end else begin : g_body
            assign prev_valid = st_valid[k-1];
            assign prev_addr  = st_addr[k-1];
            assign prev_wr_en = st_wr_en[k-1];
        end

        dest_sel_stage #(
            .ADDR_W (ADDR_W)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .advance    (adv[k]),
            .prev_valid (prev_valid),
            .prev_addr  (prev_addr),
            .prev_wr_en (prev_wr_en),
            .valid      (st_valid[k]),
            .addr       (st_addr[k]),
            .wr_en      (st_wr_en[k])
        );
    end

    assign bus.out_valid = st_valid[STAGES-1];
    assign bus.out_addr  = st_addr[STAGES-1];
    assign bus.out_wr_en = st_valid[STAGES-1] && st_wr_en[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (in_fire && !in_range) begin
            sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dest_addr_sel_pipe.sv
// Four pipeline configurations driven by directed and random traffic, checked every cycle
// against a queue model that predicts each entry's output cycle from acceptance time and predecessor.
module tb_dest_addr_sel_pipe;
    import dest_sel_pkg::*;

    localparam int NG = 4;

    function automatic int ni_of(input int g);
        case (g)
            0:       return 4;
            1:       return 3;
            2:       return 16;
            default: return 2;
        endcase
    endfunction

    function automatic int st_of(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 3;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NG-1:0] rst, flsh, iv, ordy;
    logic [3:0]    isel  [NG];
    logic [79:0]   iaddr [NG];
    logic [NG-1:0] irdy, ov, owr, oerr;
    logic [4:0]    oaddr [NG];

    for (genvar g = 0; g < NG; g++) begin : gi
        localparam int NI = ni_of(g);
        localparam int ST = st_of(g);
        localparam int SW = clog2(NI);

        dest_addr_sel_pipe_if #(.ADDR_W(5), .NUM_IN(NI)) ifc ();

        assign ifc.in_valid  = iv[g];
        assign ifc.in_sel    = isel[g][SW-1:0];
        assign ifc.in_addr   = iaddr[g][NI*5-1:0];
        assign ifc.out_ready = ordy[g];
        assign irdy[g]       = ifc.in_ready;
        assign ov[g]         = ifc.out_valid;
        assign owr[g]        = ifc.out_wr_en;
        assign oaddr[g]      = ifc.out_addr;

        dest_addr_sel_pipe #(.ADDR_W(5), .NUM_IN(NI), .STAGES(ST)) dut (
            .clk     (clk),
            .reset   (rst[g]),
            .flush   (flsh[g]),
            .bus     (ifc.slave),
            .sel_err (oerr[g])
        );
    end

    // Model: in-flight entries per instance, each with the earliest cycle it may be presented.
    typedef struct {
        logic [4:0] addr;
        bit         wr;
        int         rdy;
    } ent_t;

    ent_t fifo [NG][8];
    int   cnt  [NG];
    bit   merr [NG];
    bit   started [NG];
    bit   after_rst [NG];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc%0d: got %0d, want %0d", nm, g, cyc, act, exp);
        end
    endtask

    function automatic bit e_rdy(input int g);
        return ((cnt[g] < st_of(g)) || ordy[g]) && !flsh[g] && !rst[g];
    endfunction

    function automatic bit e_vld(input int g);
        return (cnt[g] > 0) && (cyc >= fifo[g][0].rdy);
    endfunction

    task automatic compare_all();
        for (int g = 0; g < NG; g++) begin
            if (started[g]) begin
                chk("out_valid", g, ov[g], e_vld(g));
                chk("in_ready", g, irdy[g], e_rdy(g));
                chk("sel_err", g, oerr[g], merr[g]);
                if (e_vld(g)) begin
                    chk("out_addr", g, oaddr[g], fifo[g][0].addr);
                    chk("out_wr_en", g, owr[g], fifo[g][0].wr);
                end else begin
                    chk("idle_wr_en", g, owr[g], 0);
                end
                if (after_rst[g]) chk("rst_out_addr", g, oaddr[g], 0);
            end
        end
    endtask

    task automatic model_step();
        for (int g = 0; g < NG; g++) begin
            bit         inf, outf;
            int         sel;
            logic [4:0] a;
            inf  = iv[g] && e_rdy(g);
            outf = e_vld(g) && ordy[g];
            after_rst[g] = rst[g];
            if (rst[g]) begin
                cnt[g] = 0;
                merr[g] = 0;
                started[g] = 1;
            end else if (flsh[g]) begin
                cnt[g] = 0;
            end else begin
                if (outf) begin
                    for (int j = 0; j < 7; j++) fifo[g][j] = fifo[g][j+1];
                    cnt[g]--;
                    if (cnt[g] > 0 && fifo[g][0].rdy < cyc + 1) fifo[g][0].rdy = cyc + 1;
                end
                if (inf) begin
                    sel = int'(isel[g]);
                    a = (sel < ni_of(g)) ? iaddr[g][sel*5 +: 5] : 5'd0;
                    fifo[g][cnt[g]] = '{addr: a, wr: (sel < ni_of(g)) && (a != 5'd0), rdy: cyc + st_of(g)};
                    cnt[g]++;
                    if (sel >= ni_of(g)) merr[g] = 1;
                end
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] lit_a [4] = '{5'd5, 5'd9, 5'd31, 5'd0};
    logic       lit_w [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] rx [8];
    logic [4:0] first;
    logic       fire;
    int         k, stall_acc, nrx, nout;

    initial begin
        rst = '1; flsh = '0; iv = '0; ordy = '1;
        for (int g = 0; g < NG; g++) begin
            isel[g] = '0;
            iaddr[g] = '0;
            cnt[g] = 0; merr[g] = 0; started[g] = 0; after_rst[g] = 0;
        end
        fork
            forever begin
                @(negedge clk);
                compare_all();
                @(posedge clk);
                model_step();
            end
        join_none

        // Reset values
        @(negedge clk);
        chk("rst_cycle_in_ready", 0, irdy[0], 0);
        tick();
        rst = '0;
        @(negedge clk);
        chk("post_rst_in_ready", 0, irdy[0], 1);
        chk("post_rst_out_valid", 0, ov[0], 0);
        chk("post_rst_wr_en", 0, owr[0], 0);
        chk("post_rst_addr", 0, oaddr[0], 0);
        chk("post_rst_sel_err", 0, oerr[0], 0);
        tick();

        // Streaming, back-to-back, two-cycle latency
        iaddr[0][4:0] = 5'd5; iaddr[0][9:5] = 5'd9; iaddr[0][14:10] = 5'd31; iaddr[0][19:15] = 5'd0;
        for (int i = 0; i < 6; i++) begin
            iv[0] = (i < 4);
            isel[0] = (i < 4) ? 4'(i) : 4'd0;
            @(negedge clk);
            if (i >= 2) begin
                chk("stream_valid", 0, ov[0], 1);
                chk("stream_addr", 0, oaddr[0], lit_a[i-2]);
                chk("stream_wr_en", 0, owr[0], lit_w[i-2]);
            end
            tick();
        end

        // Backpressure: capacity two, then ordered drain
        ordy[0] = 0; k = 0; stall_acc = 0; nrx = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 8) ordy[0] = 1;
            iv[0] = (k < 5);
            isel[0] = 4'd1;
            iaddr[0][9:5] = 5'(10 + k);
            @(negedge clk);
            fire = iv[0] && irdy[0];
            if (fire && c < 8) stall_acc++;
            if (c == 2) chk("stall_in_ready", 0, irdy[0], 0);
            if (ov[0] && ordy[0] && nrx < 8) begin
                rx[nrx] = oaddr[0];
                nrx++;
            end
            tick();
            if (fire) k++;
        end
        chk("stall_accepted", 0, stall_acc, 2);
        chk("drain_count", 0, nrx, 5);
        for (int j = 0; j < 5; j++) chk("drain_order", 0, rx[j], 10 + j);

        // Flush with a same-cycle offer
        ordy[0] = 0; iv[0] = 1; isel[0] = 4'd1;
        iaddr[0][9:5] = 5'd20; tick();
        iaddr[0][9:5] = 5'd21; tick();
        flsh[0] = 1; iaddr[0][9:5] = 5'd22;
        @(negedge clk);
        chk("flush_in_ready", 0, irdy[0], 0);
        tick();
        flsh[0] = 0; iv[0] = 0; ordy[0] = 1;
        @(negedge clk);
        chk("flush_out_valid", 0, ov[0], 0);
        tick();
        iv[0] = 1; iaddr[0][9:5] = 5'd23;
        tick();
        iv[0] = 0; nout = 0; first = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ov[0]) begin
                if (nout == 0) first = oaddr[0];
                nout++;
            end
            tick();
        end
        chk("flush_survivors", 0, nout, 1);
        chk("flush_first_addr", 0, first, 23);

        // Out-of-range select on three candidates, sticky until reset
        iaddr[1][4:0] = 5'd7; iaddr[1][9:5] = 5'd8; iaddr[1][14:10] = 5'd9; iaddr[1][19:15] = 5'd17;
        iv[1] = 1; isel[1] = 4'd3; ordy[1] = 1;
        @(negedge clk);
        chk("oor_err_before", 1, oerr[1], 0);
        tick();
        isel[1] = 4'd0;
        @(negedge clk);
        chk("oor_err_set", 1, oerr[1], 1);
        chk("oor_out_valid", 1, ov[1], 1);
        chk("oor_out_addr", 1, oaddr[1], 0);
        chk("oor_out_wr_en", 1, owr[1], 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            isel[1] = 4'(i + 1 > 2 ? 2 : i + 1);
            @(negedge clk);
            chk("oor_err_held", 1, oerr[1], 1);
        end
        tick();
        iv[1] = 0; rst[1] = 1;
        tick();
        rst[1] = 0;
        @(negedge clk);
        chk("oor_err_cleared", 1, oerr[1], 0);
        tick();

        // Reset mid-stream with a full pipeline
        ordy[0] = 0; iv[0] = 1; isel[0] = 4'd2;
        for (int i = 0; i < 3; i++) begin
            iaddr[0][14:10] = 5'(1 + i);
            tick();
        end
        iv[0] = 0; rst[0] = 1;
        tick();
        rst[0] = 0;
        @(negedge clk);
        chk("midrst_out_valid", 0, ov[0], 0);
        chk("midrst_wr_en", 0, owr[0], 0);
        chk("midrst_addr", 0, oaddr[0], 0);
        chk("midrst_in_ready", 0, irdy[0], 1);
        tick();
        ordy[0] = 1; iv[0] = 1; iaddr[0][14:10] = 5'd6;
        tick();
        iv[0] = 0;
        tick();
        @(negedge clk);
        chk("resume_valid", 0, ov[0], 1);
        chk("resume_addr", 0, oaddr[0], 6);
        tick();

        // Random traffic on all configurations
        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < NG; g++) begin
                iv[g]    = ($urandom_range(0, 3) != 0);
                ordy[g]  = ($urandom_range(0, 2) != 0);
                isel[g]  = 4'($urandom_range(0, (1 << clog2(ni_of(g))) - 1));
                iaddr[g] = {16'($urandom), $urandom, $urandom};
                flsh[g]  = ($urandom_range(0, 39) == 0);
                rst[g]   = ($urandom_range(0, 149) == 0);
            end
            tick();
        end
        iv = '0; flsh = '0; rst = '0; ordy = '1;
        for (int c = 0; c < 8; c++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
